// File: rtl/syn_clk_extender_pkg.sv
// Shared constants for the sync-clock extender: default widths, FSM state codes, mode encoding.
// Imported by the interface, the wrap detector and the top.
package syn_clk_pkg;

    localparam int TIME_W_DEF   = 64;
    localparam int CYCLE_W_DEF  = 32;
    localparam int WRAP_WIN_DEF = 64;
    localparam int WCNT_W_DEF   = 16;

    typedef logic [1:0] state_t;

    localparam state_t S_INIT  = 2'd0;
    localparam state_t S_PASS  = 2'd1;
    localparam state_t S_TRACK = 2'd2;

    localparam logic MODE_1588 = 1'b1;
    localparam logic MODE_6802 = 1'b0;

endpackage

// File: rtl/syn_clk_extender_if.sv
// Sample-in / extended-time-out bundle between the sync-clock generator and its consumers.
// slave = extender side, master = producer/observer side.
interface syn_clk_extender_if
    import syn_clk_pkg::*;
#(
    parameter int TIME_W  = TIME_W_DEF,
    parameter int CYCLE_W = CYCLE_W_DEF,
    parameter int WCNT_W  = WCNT_W_DEF
);
    logic [TIME_W-1:0]  iv_syn_clk;
    logic               i_syn_clk_valid;
    logic               i_tsn_or_tte;
    logic [CYCLE_W-1:0] iv_syn_clk_cycle;
    logic [TIME_W-1:0]  ov_syn_clk;
    logic               o_syn_clk_valid;
    logic               o_wrap_pulse;
    logic [WCNT_W-1:0]  ov_wrap_cnt;
    logic               o_jump_err;

    modport slave (
        input  iv_syn_clk, i_syn_clk_valid, i_tsn_or_tte, iv_syn_clk_cycle,
        output ov_syn_clk, o_syn_clk_valid, o_wrap_pulse, ov_wrap_cnt, o_jump_err
    );

    modport master (
        output iv_syn_clk, i_syn_clk_valid, i_tsn_or_tte, iv_syn_clk_cycle,
        input  ov_syn_clk, o_syn_clk_valid, o_wrap_pulse, ov_wrap_cnt, o_jump_err
    );
endinterface

// File: rtl/syn_clk_extender_wrap_detect.sv
// Combinational backward-step classifier: a wrap is a backward step from within WRAP_WIN of the cycle end.
// Zero latency; no flow control. back/jump are forced low when jump detection is not built in.
module syn_wrap_detect
    import syn_clk_pkg::*;
#(
    parameter int TIME_W   = TIME_W_DEF,
    parameter int CYCLE_W  = CYCLE_W_DEF,
    parameter int WRAP_WIN = WRAP_WIN_DEF,
    parameter bit JUMP_EN  = 1'b0
) (
    input  logic [TIME_W-1:0]  cur,
    input  logic [TIME_W-1:0]  prev,
    input  logic [CYCLE_W-1:0] cycle,
    output logic               back,
    output logic               wrap,
    output logic               jump
);
    localparam logic [CYCLE_W:0] WIN = (CYCLE_W+1)'(WRAP_WIN);

    logic [CYCLE_W:0]   cyc_x;
    logic [CYCLE_W-1:0] thr;
    logic               step_back;

    always_comb begin
        cyc_x     = {1'b0, cycle};
        // Window start saturates at 0 for cycles shorter than the window.
        thr       = (cyc_x >= WIN) ? CYCLE_W'(cyc_x - WIN) : '0;
        step_back = (cur < prev);
        wrap      = step_back && (prev >= TIME_W'(thr));
        back      = JUMP_EN && step_back;
        jump      = back && !wrap;
    end
endmodule

// File: rtl/syn_clk_extender.sv
// Extends cyclic 6802/TTE sync time to monotonic global time (1588 passed through); 1-cycle registered latency.
// No backpressure: one sample per valid cycle. Optional SYN_CLK_JUMP_DET_EN restarts on illegal backward steps.
module syn_clk_extender
    import syn_clk_pkg::*;
#(
    parameter int TIME_W   = TIME_W_DEF,
    parameter int CYCLE_W  = CYCLE_W_DEF,
    parameter int WRAP_WIN = WRAP_WIN_DEF,
    parameter int WCNT_W   = WCNT_W_DEF
) (
    input logic               i_clk,
    input logic               i_rst_n,
    syn_clk_extender_if.slave bus
);
`ifdef SYN_CLK_JUMP_DET_EN
    localparam bit JUMP_EN = 1'b1;
`else
    localparam bit JUMP_EN = 1'b0;
`endif

    state_t             state;
    logic [TIME_W-1:0]  offset;
    logic [TIME_W-1:0]  offset_n;
    logic [TIME_W-1:0]  prev;
    logic [CYCLE_W-1:0] cyc_q;
    logic               mode_q;
    logic               back, wrap, jump;
    logic               restart, jump_hit, wrap_hit;

    syn_wrap_detect #(
        .TIME_W   (TIME_W),
        .CYCLE_W  (CYCLE_W),
        .WRAP_WIN (WRAP_WIN),
        .JUMP_EN  (JUMP_EN)
    ) u_wrap_detect (
        .cur   (bus.iv_syn_clk),
        .prev  (prev),
        .cycle (cyc_q),
        .back  (back),
        .wrap  (wrap),
        .jump  (jump)
    );

    always_comb begin
        restart  = (bus.i_tsn_or_tte != mode_q) ||
                   ((state == S_TRACK) && (bus.iv_syn_clk_cycle != cyc_q));
        jump_hit = bus.i_syn_clk_valid &&
                   (((state == S_PASS) && back) || ((state == S_TRACK) && jump));
        wrap_hit = bus.i_syn_clk_valid && (state == S_TRACK) && wrap;
        offset_n = wrap_hit ? (offset + TIME_W'(cyc_q)) : offset;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state               <= S_INIT;
            offset              <= '0;
            prev                <= '0;
            cyc_q               <= '0;
            mode_q              <= 1'b0;
            bus.ov_syn_clk      <= '0;
            bus.o_syn_clk_valid <= 1'b0;
            bus.o_wrap_pulse    <= 1'b0;
            bus.ov_wrap_cnt     <= '0;
            bus.o_jump_err      <= 1'b0;
        end else begin
            mode_q              <= bus.i_tsn_or_tte;
            bus.o_syn_clk_valid <= 1'b0;
            bus.o_wrap_pulse    <= 1'b0;
            bus.o_jump_err      <= 1'b0;
            // Restart wins over sample processing; ov_syn_clk keeps its last value.
            if (restart || jump_hit) begin
                state           <= S_INIT;
                offset          <= '0;
                prev            <= '0;
                bus.ov_wrap_cnt <= '0;
                bus.o_jump_err  <= jump_hit;
            end else if (bus.i_syn_clk_valid) begin
                case (state)
                    S_INIT: begin
                        prev  <= bus.iv_syn_clk;
                        cyc_q <= bus.iv_syn_clk_cycle;
                        state <= (bus.i_tsn_or_tte == MODE_1588) ? S_PASS : S_TRACK;
                    end
                    S_PASS: begin
                        prev                <= bus.iv_syn_clk;
                        offset              <= '0;
                        bus.ov_syn_clk      <= bus.iv_syn_clk;
                        bus.o_syn_clk_valid <= 1'b1;
                    end
                    S_TRACK: begin
                        prev                <= bus.iv_syn_clk;
                        offset              <= offset_n;
                        bus.ov_syn_clk      <= offset_n + bus.iv_syn_clk;
                        bus.o_syn_clk_valid <= 1'b1;
                        if (wrap_hit) begin
                            bus.o_wrap_pulse <= 1'b1;
                            if (!(&bus.ov_wrap_cnt))
                                bus.ov_wrap_cnt <= bus.ov_wrap_cnt + 1'b1;
                        end
                    end
                    default: state <= S_INIT;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_syn_clk_extender.sv
// Directed scoreboard bench for syn_clk_extender: 1588 passthrough, 6802 wraps, restarts, jumps, async reset.
module tb_syn_clk_extender;
    import syn_clk_pkg::*;

    typedef struct {
        logic        vld;
        logic [63:0] dat;
        logic        wrap;
        logic [15:0] cnt;
        logic        jmp;
    } exp_t;

    logic clk;
    logic rst_n;
    int   vec  = 0;
    int   miss = 0;
    int   stp  = 0;
    exp_t sb[$];
    logic [63:0] off;
    logic [15:0] cnt;

    syn_clk_extender_if bus ();

    syn_clk_extender dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s step %0d: observed %0d expected %0d", tag, stp, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_dat"},  bus.ov_syn_clk, 64'd0);
        chk({tag, "_vld"},  64'(bus.o_syn_clk_valid), 64'd0);
        chk({tag, "_wrap"}, 64'(bus.o_wrap_pulse), 64'd0);
        chk({tag, "_cnt"},  64'(bus.ov_wrap_cnt), 64'd0);
        chk({tag, "_jmp"},  64'(bus.o_jump_err), 64'd0);
    endtask

    // Drive one input cycle, queue what the output must look like after the edge, then compare.
    task automatic step(input logic v, input logic [63:0] raw,
                        input logic ev, input logic [63:0] ed,
                        input logic ew, input logic [15:0] ec, input logic ej);
        exp_t e;
        bus.i_syn_clk_valid = v;
        bus.iv_syn_clk      = raw;
        e.vld = ev; e.dat = ed; e.wrap = ew; e.cnt = ec; e.jmp = ej;
        sb.push_back(e);
        @(posedge clk);
        #1;
        stp++;
        e = sb.pop_front();
        chk("vld",  64'(bus.o_syn_clk_valid), 64'(e.vld));
        chk("dat",  bus.ov_syn_clk, e.dat);
        chk("wrap", 64'(bus.o_wrap_pulse), 64'(e.wrap));
        chk("cnt",  64'(bus.ov_wrap_cnt), 64'(e.cnt));
        chk("jmp",  64'(bus.o_jump_err), 64'(e.jmp));
    endtask

    initial begin
        rst_n                = 1'b0;
        bus.i_tsn_or_tte     = MODE_1588;
        bus.iv_syn_clk_cycle = 32'd1000;
        bus.i_syn_clk_valid  = 1'b0;
        bus.iv_syn_clk       = '0;
        #8;
        chk_idle_zero("reset");
        #4;
        rst_n = 1'b1;

        // 1588 passthrough: first sample only primes S_INIT
        step(0, 64'h0,    0, 64'h0,    0, 0, 0);
        step(0, 64'h0,    0, 64'h0,    0, 0, 0);
        step(1, 64'h1230, 0, 64'h0,    0, 0, 0);
        step(1, 64'h1234, 1, 64'h1234, 0, 0, 0);
        step(1, 64'h123C, 1, 64'h123C, 0, 0, 0);
        step(0, 64'h0,    0, 64'h123C, 0, 0, 0);

        // 6802 mode, cycle 1000: mode toggle restarts
        bus.i_tsn_or_tte = MODE_6802;
        step(0, 64'd0,   0, 64'h123C,  0, 0, 0);
        step(1, 64'd976, 0, 64'h123C,  0, 0, 0);
        step(1, 64'd984, 1, 64'd984,   0, 0, 0);
        step(1, 64'd992, 1, 64'd992,   0, 0, 0);
        step(1, 64'd0,   1, 64'd1000,  1, 1, 0);
        step(1, 64'd8,   1, 64'd1008,  0, 1, 0);

        // More wraps with idle gaps
        step(0, 64'd0,   0, 64'd1008,  0, 1, 0);
        step(1, 64'd992, 1, 64'd1992,  0, 1, 0);
        step(0, 64'd5,   0, 64'd1992,  0, 1, 0);
        step(1, 64'd0,   1, 64'd2000,  1, 2, 0);
        step(1, 64'd992, 1, 64'd2992,  0, 2, 0);
        step(1, 64'd0,   1, 64'd3000,  1, 3, 0);

        // Cycle length change restarts tracking
        bus.iv_syn_clk_cycle = 32'd2000;
        step(0, 64'd0,    0, 64'd3000, 0, 0, 0);
        step(1, 64'd1500, 0, 64'd3000, 0, 0, 0);
        step(1, 64'd1508, 1, 64'd1508, 0, 0, 0);

        bus.iv_syn_clk_cycle = 32'd1000;
        step(0, 64'd0,   0, 64'd1508, 0, 0, 0);
        step(1, 64'd400, 0, 64'd1508, 0, 0, 0);
        step(1, 64'd500, 1, 64'd500,  0, 0, 0);
`ifdef SYN_CLK_JUMP_DET_EN
        step(1, 64'd100, 0, 64'd500,  0, 0, 1);
        step(1, 64'd100, 0, 64'd500,  0, 0, 0);
        step(1, 64'd108, 1, 64'd108,  0, 0, 0);
        off = 64'd0;
        cnt = 16'd0;
`else
        step(1, 64'd100, 1, 64'd100,  0, 0, 0);
        // Wrap window edge: 1000-64 = 936
        step(1, 64'd935, 1, 64'd935,  0, 0, 0);
        step(1, 64'd10,  1, 64'd10,   0, 0, 0);
        step(1, 64'd936, 1, 64'd936,  0, 0, 0);
        step(1, 64'd10,  1, 64'd1010, 1, 1, 0);
        off = 64'd1000;
        cnt = 16'd1;
`endif
        while (off < 64'd5000) begin
            step(1, 64'd992, 1, off + 64'd992, 0, cnt, 0);
            off = off + 64'd1000;
            cnt = cnt + 16'd1;
            step(1, 64'd0, 1, off, 1, cnt, 0);
        end

        // Async reset mid-track
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle_zero("arst");
        bus.i_syn_clk_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1, 64'd50, 0, 64'd0,  0, 0, 0);
        step(1, 64'd60, 1, 64'd60, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
